// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// CPU side: byte-wide READ/WRITE/ADDRESS bus with BUSYWAIT stall.
// Memory side: 32-bit block transfers with a mem_busywait handshake.
// Handshake: a memory strobe (mem_read or mem_write) is raised with its
// address/data and held unchanged until the edge where mem_busywait is low;
// that edge completes the transfer and the strobe drops or switches.
module dcache_ctrl #(
  parameter int INDEX_W = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait,
  output logic [1:0]  dbg_state
);

  localparam int TAG_W  = 8 - INDEX_W - 2;
  localparam int NLINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_READ  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t             state;
  logic [NLINES-1:0]  valid;
  logic [NLINES-1:0]  dirty;
  logic [TAG_W-1:0]   tags  [NLINES];
  logic [31:0]        data  [NLINES];

  // Miss target is latched so a request dropped mid-miss still fills the right line.
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_idx;

  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         off;
  logic               req;
  logic               hit;
  logic [31:0]        sel_block;

  assign addr_tag  = ADDRESS[7:INDEX_W+2];
  assign idx       = ADDRESS[INDEX_W+1:2];
  assign off       = ADDRESS[1:0];
  assign req       = READ | WRITE;
  assign sel_block = data[idx];
  assign hit       = valid[idx] && (tags[idx] == addr_tag);
  assign dbg_state = state;

  // CPU-facing outputs: hits answer in the same cycle, misses stall at once.
  always_comb begin
    BUSYWAIT = 1'b0;
    READDATA = 8'h00;
    if (RESET) begin
      if (state != IDLE) begin
        BUSYWAIT = 1'b1;
      end else if (req && !hit) begin
        BUSYWAIT = 1'b1;
      end else if (READ && !WRITE && hit) begin
        READDATA = sel_block[{off, 3'b000} +: 8];
      end
    end
  end

  // Controller FSM with line status bits and registered memory strobes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      miss_tag      <= '0;
      miss_idx      <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (WRITE) dirty[idx] <= 1'b1;
          end else if (req) begin
            miss_tag <= addr_tag;
            miss_idx <= idx;
            if (valid[idx] && dirty[idx]) begin
              state         <= MEM_WRITE;
              mem_write     <= 1'b1;
              mem_address   <= {tags[idx], idx};
              mem_writedata <= sel_block;
            end else begin
              state       <= MEM_READ;
              mem_read    <= 1'b1;
              mem_address <= {addr_tag, idx};
            end
          end
        end
        MEM_WRITE: begin
          if (!mem_busywait) begin
            dirty[miss_idx] <= 1'b0;
            mem_write       <= 1'b0;
            mem_read        <= 1'b1;
            mem_address     <= {miss_tag, miss_idx};
            state           <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
            mem_read        <= 1'b0;
            mem_address     <= '0;
            state           <= UPDATE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line data and tags: byte merge on write hits, whole-block load on fill.
  always_ff @(posedge CLK) begin
    if (state == IDLE && req && hit && WRITE) begin
      data[idx][{off, 3'b000} +: 8] <= WRITEDATA;
    end else if (state == MEM_READ && !mem_busywait) begin
      data[miss_idx] <= mem_readdata;
      tags[miss_idx] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: directed scenarios plus random traffic,
// checked against a line-level cache model and a reference memory image.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic        mem_busywait = 1'b0;
  logic [1:0]  dbg_state;

  dcache_ctrl #(.INDEX_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Memory environment: each transfer takes 'lat' cycles, busywait low on the last.
  logic [31:0] env_mem [64];
  int lat  = 1;
  int mcnt = 0;
  always @(negedge CLK) begin
    if (!RESET || !(mem_read || mem_write)) begin
      mcnt = 0;
      mem_busywait = 1'b0;
    end else begin
      mcnt++;
      if (mcnt >= lat) begin
        mem_busywait = 1'b0;
        mcnt = 0;
        if (mem_write) env_mem[mem_address] = mem_writedata;
        else mem_readdata = env_mem[mem_address];
      end else begin
        mem_busywait = 1'b1;
      end
    end
  end

  // Reference model: line state and memory image
  bit          r_valid [8];
  bit          r_dirty [8];
  logic [2:0]  r_tag   [8];
  logic [31:0] r_data  [8];
  logic [31:0] r_mem   [64];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_byte(input logic [7:0] a);
    logic [31:0] blk;
    blk = r_data[a[4:2]];
    return blk[a[1:0]*8 +: 8];
  endfunction

  // Model a miss on address a: write back a dirty victim, then fill.
  task automatic model_miss(input logic [7:0] a);
    int i;
    i = a[4:2];
    if (r_valid[i] && r_dirty[i]) r_mem[{r_tag[i], a[4:2]}] = r_data[i];
    r_data[i]  = r_mem[a[7:2]];
    r_tag[i]   = a[7:5];
    r_valid[i] = 1'b1;
    r_dirty[i] = 1'b0;
  endtask

  // One CPU request, held until completion; called at posedge+1.
  task automatic do_req(input bit wr, input bit both, input logic [7:0] a, input logic [7:0] d);
    int i, off, n;
    bit hit, evict, saw_w, saw_r, both_err;
    logic [5:0]  ev_addr, w_addr, r_addr;
    logic [31:0] ev_data, w_data;
    i = a[4:2];
    off = a[1:0];
    hit = r_valid[i] && (r_tag[i] == a[7:5]);
    evict = !hit && r_valid[i] && r_dirty[i];
    ev_addr = {r_tag[i], a[4:2]};
    ev_data = r_data[i];
    lat = $urandom_range(1, 4);
    READ = !wr || both;
    WRITE = wr;
    ADDRESS = a;
    WRITEDATA = d;
    #1;
    chk("busywait_on_request", 32'(BUSYWAIT), 32'(!hit));
    if (hit) begin
      chk("no_mem_strobe_on_hit", 32'({mem_read, mem_write}), 32'h0);
      if (!wr) chk("readdata_hit", 32'(READDATA), 32'(ref_byte(a)));
    end else begin
      saw_w = 0; saw_r = 0; both_err = 0; n = 0;
      w_addr = '0; w_data = '0; r_addr = '0;
      do begin
        @(posedge CLK); #2; n++;
        if (mem_read && mem_write) both_err = 1;
        if (mem_write && !saw_w) begin saw_w = 1; w_addr = mem_address; w_data = mem_writedata; end
        if (mem_read && !saw_r) begin saw_r = 1; r_addr = mem_address; end
      end while (BUSYWAIT && n < 60);
      chk("miss_completes", 32'(BUSYWAIT), 32'h0);
      chk("strobes_exclusive", 32'(both_err), 32'h0);
      chk("writeback_seen", 32'(saw_w), 32'(evict));
      if (evict) begin
        chk("writeback_addr", 32'(w_addr), 32'(ev_addr));
        chk("writeback_data", w_data, ev_data);
      end
      chk("fill_seen", 32'(saw_r), 32'h1);
      chk("fill_addr", 32'(r_addr), 32'(a[7:2]));
      model_miss(a);
      if (!wr) chk("readdata_after_fill", 32'(READDATA), 32'(ref_byte(a)));
    end
    @(posedge CLK);
    if (wr) begin
      r_data[i][off*8 +: 8] = d;
      r_dirty[i] = 1'b1;
    end
    #1;
    READ = 1'b0;
    WRITE = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] a;
    logic [2:0] tg, ix;
    logic [1:0] of;
    for (int k = 0; k < 64; k++) begin
      r_mem[k] = $urandom;
    end
    r_mem[1] = 32'h44332211;
    for (int k = 0; k < 64; k++) env_mem[k] = r_mem[k];
    for (int k = 0; k < 8; k++) begin
      r_valid[k] = 0; r_dirty[k] = 0; r_tag[k] = '0; r_data[k] = '0;
    end

    // Reset values
    #12;
    chk("reset_busywait", 32'(BUSYWAIT), 32'h0);
    chk("reset_readdata", 32'(READDATA), 32'h0);
    chk("reset_mem_read", 32'(mem_read), 32'h0);
    chk("reset_mem_write", 32'(mem_write), 32'h0);
    chk("reset_mem_address", 32'(mem_address), 32'h0);
    chk("reset_mem_writedata", mem_writedata, 32'h0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    // Directed scenarios
    do_req(0, 0, 8'h04, 8'h00);
    do_req(0, 0, 8'h06, 8'h00);
    do_req(1, 0, 8'h05, 8'hAB);
    do_req(0, 0, 8'h05, 8'h00);
    do_req(0, 0, 8'h24, 8'h00);
    do_req(1, 0, 8'h48, 8'h5A);
    do_req(0, 0, 8'h48, 8'h00);
    do_req(0, 0, 8'h00, 8'h00);
    do_req(1, 0, 8'h01, 8'hC3);
    do_req(0, 0, 8'h20, 8'h00);
    do_req(0, 0, 8'h00, 8'h00);
    do_req(1, 1, 8'h02, 8'h7E);
    do_req(0, 0, 8'h02, 8'h00);

    // Request dropped mid-miss: the line must still be filled
    lat = 2;
    READ = 1'b1; ADDRESS = 8'h9C; n = 0;
    do begin @(posedge CLK); #2; n++; end while (!mem_read && n < 30);
    chk("drop_fill_started", 32'(mem_read), 32'h1);
    READ = 1'b0;
    n = 0;
    do begin @(posedge CLK); #2; n++; end while (BUSYWAIT && n < 30);
    chk("drop_fill_completes", 32'(BUSYWAIT), 32'h0);
    model_miss(8'h9C);
    @(posedge CLK); #1;
    do_req(0, 0, 8'h9D, 8'h00);

    // Random traffic over a few tags so lines collide and get evicted
    for (int k = 0; k < 300; k++) begin
      tg = 3'($urandom_range(0, 3));
      ix = 3'($urandom_range(0, 7));
      of = 2'($urandom_range(0, 3));
      a = {tg, ix, of};
      do_req($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, a, 8'($urandom));
    end

    // Reset in the middle of a fill
    READ = 1'b1; ADDRESS = 8'hE0; n = 0;
    lat = 3;
    if (r_valid[0] && r_dirty[0]) r_mem[{r_tag[0], 3'b000}] = r_data[0];
    do begin @(posedge CLK); #2; n++; end while (!mem_read && n < 40);
    chk("reset_test_fill_started", 32'(mem_read), 32'h1);
    #1; RESET = 1'b0; #1;
    chk("reset_drops_mem_read", 32'(mem_read), 32'h0);
    chk("reset_drops_busywait", 32'(BUSYWAIT), 32'h0);
    chk("reset_no_mem_write", 32'(mem_write), 32'h0);
    for (int k = 0; k < 8; k++) begin r_valid[k] = 0; r_dirty[k] = 0; end
    READ = 1'b0;
    #10; RESET = 1'b1;
    @(posedge CLK); #1;
    do_req(0, 0, 8'hE0, 8'h00);
    do_req(0, 0, 8'hE3, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
